// File: rtl/voice_activity_detector_if.sv
// Sample/noise/threshold stream into the voice activity detector and its frame/word results.
// master drives the stream (source side), slave is the detector.
interface voice_activity_detector_if #(
  parameter int ENERGY_W = 14
);
  logic [7:0]          sample_in;
  logic                sample_valid;
  logic [7:0]          noise;
  logic                noise_en;
  logic [ENERGY_W-1:0] threshold;
  logic [ENERGY_W-1:0] energy_out;
  logic                energy_valid;
  logic                voice_active;
  logic [3:0]          word_count;
  logic                word_pulse;

  modport master (
    output sample_in, sample_valid, noise, noise_en, threshold,
    input  energy_out, energy_valid, voice_active, word_count, word_pulse
  );

  modport slave (
    input  sample_in, sample_valid, noise, noise_en, threshold,
    output energy_out, energy_valid, voice_active, word_count, word_pulse
  );
endinterface

// File: rtl/voice_activity_detector.sv
// Noise-mixing frame-energy meter with a hysteresis FSM that flags speech and counts words (BCD).
// Pipeline: saturating mix -> |x| accumulate per frame -> FSM one cycle after each frame result.
module voice_activity_detector #(
  parameter int FRAME_LOG2  = 6,
  parameter int ENERGY_W    = 14,
  parameter int NOISE_SHIFT = 2,
  parameter int ON_FRAMES   = 2,
  parameter int OFF_FRAMES  = 4
) (
  input logic                        clk,
  input logic                        reset,
  voice_activity_detector_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_SILENT   = 2'd0,
    ST_ONSET    = 2'd1,
    ST_VOICE    = 2'd2,
    ST_HANGOVER = 2'd3
  } state_e;

  localparam logic [FRAME_LOG2-1:0] CNT_LAST = '1;
  localparam logic [7:0]            ON_LIM   = 8'(ON_FRAMES);
  localparam logic [7:0]            OFF_LIM  = 8'(OFF_FRAMES);

  logic signed [7:0]   noise_sh_s;
  logic signed [7:0]   noise_term_s;
  logic        [8:0]   sum_s;
  logic        [7:0]   sat_s;
  logic        [7:0]   mag_s;
  logic [ENERGY_W-1:0] acc_sum_s;
  logic                loud_s;

  logic        [7:0]   mixed_q;
  logic                s1_v_q;
  logic [ENERGY_W-1:0] acc_q;
  logic [FRAME_LOG2-1:0] cnt_q;
  logic [ENERGY_W-1:0] energy_out_q;
  logic                energy_valid_q;

  state_e     state_q, state_d;
  logic [7:0] on_cnt_q, on_cnt_d;
  logic [7:0] off_cnt_q, off_cnt_d;
  logic [3:0] word_count_q, word_count_d;
  logic       word_pulse_q, word_pulse_d;
  logic       voice_active_q, voice_active_d;

  assign noise_sh_s = $signed(bus.noise) >>> NOISE_SHIFT;

  // 9-bit sum of two sign-extended bytes; bits 8 and 7 disagree exactly on overflow
  always_comb begin
    noise_term_s = bus.noise_en ? noise_sh_s : 8'sd0;
    sum_s        = {bus.sample_in[7], bus.sample_in} + {noise_term_s[7], noise_term_s};
    if (sum_s[8] != sum_s[7]) begin
      sat_s = sum_s[8] ? 8'h80 : 8'h7F;
    end else begin
      sat_s = sum_s[7:0];
    end
  end

  // Stage 1 register: mixed sample and its valid
  always_ff @(posedge clk) begin
    if (reset) begin
      mixed_q <= 8'd0;
      s1_v_q  <= 1'b0;
    end else begin
      s1_v_q <= bus.sample_valid;
      if (bus.sample_valid) begin
        mixed_q <= sat_s;
      end
    end
  end

  // -128 negates to 0x80, which read unsigned is the required 128
  assign mag_s     = mixed_q[7] ? (~mixed_q + 8'd1) : mixed_q;
  assign acc_sum_s = acc_q + ENERGY_W'(mag_s);

  // Stage 2 register: frame accumulator and frame-energy result
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      cnt_q          <= '0;
      energy_out_q   <= '0;
      energy_valid_q <= 1'b0;
    end else begin
      energy_valid_q <= 1'b0;
      if (s1_v_q) begin
        if (cnt_q == CNT_LAST) begin
          energy_out_q   <= acc_sum_s;
          energy_valid_q <= 1'b1;
          acc_q          <= '0;
          cnt_q          <= '0;
        end else begin
          acc_q <= acc_sum_s;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign loud_s = (energy_out_q >= bus.threshold);

  // Hysteresis next-state: only advances on a freshly completed frame
  always_comb begin
    state_d      = state_q;
    on_cnt_d     = on_cnt_q;
    off_cnt_d    = off_cnt_q;
    word_count_d = word_count_q;
    word_pulse_d = 1'b0;
    if (energy_valid_q) begin
      case (state_q)
        ST_SILENT: begin
          if (loud_s) begin
            state_d  = ST_ONSET;
            on_cnt_d = 8'd1;
          end else begin
            state_d  = ST_SILENT;
          end
        end
        ST_ONSET: begin
          if (!loud_s) begin
            state_d  = ST_SILENT;
            on_cnt_d = 8'd0;
          end else if (on_cnt_q + 8'd1 == ON_LIM) begin
            state_d      = ST_VOICE;
            on_cnt_d     = 8'd0;
            word_pulse_d = 1'b1;
            word_count_d = (word_count_q == 4'd9) ? 4'd0 : word_count_q + 4'd1;
          end else begin
            on_cnt_d = on_cnt_q + 8'd1;
          end
        end
        ST_VOICE: begin
          if (loud_s) begin
            state_d   = ST_VOICE;
          end else if (OFF_LIM == 8'd1) begin
            state_d   = ST_SILENT;
            off_cnt_d = 8'd0;
          end else begin
            state_d   = ST_HANGOVER;
            off_cnt_d = 8'd1;
          end
        end
        ST_HANGOVER: begin
          if (loud_s) begin
            state_d   = ST_VOICE;
            off_cnt_d = 8'd0;
          end else if (off_cnt_q + 8'd1 == OFF_LIM) begin
            state_d   = ST_SILENT;
            off_cnt_d = 8'd0;
          end else begin
            off_cnt_d = off_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d   = ST_SILENT;
          on_cnt_d  = 8'd0;
          off_cnt_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    voice_active_d = (state_d == ST_VOICE) || (state_d == ST_HANGOVER);
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_SILENT;
      on_cnt_q       <= 8'd0;
      off_cnt_q      <= 8'd0;
      word_count_q   <= 4'd0;
      word_pulse_q   <= 1'b0;
      voice_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      on_cnt_q       <= on_cnt_d;
      off_cnt_q      <= off_cnt_d;
      word_count_q   <= word_count_d;
      word_pulse_q   <= word_pulse_d;
      voice_active_q <= voice_active_d;
    end
  end

  assign bus.energy_out   = energy_out_q;
  assign bus.energy_valid = energy_valid_q;
  assign bus.voice_active = voice_active_q;
  assign bus.word_count   = word_count_q;
  assign bus.word_pulse   = word_pulse_q;

endmodule

// File: tb/tb_voice_activity_detector.sv
// Scoreboard bench for voice_activity_detector: frames push expected energy/FSM results,
// a monitor pops and compares whenever energy_valid is seen.
module tb_voice_activity_detector;

  typedef struct {
    int   energy;
    logic va;
    int   wc;
    logic wp;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   wp_total;
  logic mon_busy;
  exp_t sb[$];

  voice_activity_detector_if #(.ENERGY_W(14)) bus ();

  voice_activity_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_sample(input logic [7:0] s, input logic [7:0] nz, input logic ne,
                             input int gap);
    bus.sample_in    = s;
    bus.noise        = nz;
    bus.noise_en     = ne;
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] nz, input logic ne,
                            input int gap, input int e, input logic va, input int wc,
                            input logic wp);
    exp_t x;
    x.energy = e;
    x.va     = va;
    x.wc     = wc;
    x.wp     = wp;
    sb.push_back(x);
    for (int i = 0; i < 64; i++) send_sample(s, nz, ne, gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (n >= 400) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_energy_out"}, int'(bus.energy_out), 0);
    chk({tag, "_energy_valid"}, int'(bus.energy_valid), 0);
    chk({tag, "_voice_active"}, int'(bus.voice_active), 0);
    chk({tag, "_word_count"}, int'(bus.word_count), 0);
    chk({tag, "_word_pulse"}, int'(bus.word_pulse), 0);
  endtask

  // Monitor: compare each frame result, then the FSM outputs one cycle later
  initial begin
    exp_t e;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.energy_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_energy_valid: got energy %0d expected no frame", bus.energy_out);
        end else begin
          mon_busy = 1'b1;
          e = sb.pop_front();
          chk("energy_out", int'(bus.energy_out), e.energy);
          @(negedge clk);
          chk("energy_valid_width", int'(bus.energy_valid), 0);
          chk("voice_active", int'(bus.voice_active), int'(e.va));
          chk("word_count", int'(bus.word_count), e.wc);
          chk("word_pulse", int'(bus.word_pulse), int'(e.wp));
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    wp_total = 0;
    forever begin
      @(negedge clk);
      if (bus.word_pulse) wp_total++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.sample_in    = 8'd0;
    bus.sample_valid = 1'b0;
    bus.noise        = 8'd0;
    bus.noise_en     = 1'b0;
    bus.threshold    = 14'd16383;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");

    // 1: +10 frame, and the frame result two cycles after the last sample
    @(posedge clk);
    #1;
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("latency_t1_low", int'(bus.energy_valid), 0);
    @(negedge clk);
    chk("latency_t2_high", int'(bus.energy_valid), 1);
    drain();

    // 2: saturation and noise mixing (threshold high, all frames quiet)
    send_frame(8'h7F, 8'h7F, 1'b1, 0, 8128, 1'b0, 0, 1'b0);
    send_frame(8'h80, 8'h80, 1'b1, 0, 8192, 1'b0, 0, 1'b0);
    send_frame(8'hEC, 8'h40, 1'b1, 0, 256, 1'b0, 0, 1'b0);
    send_frame(8'd100, 8'hF0, 1'b0, 0, 6400, 1'b0, 0, 1'b0);
    send_frame(8'd100, 8'hF0, 1'b1, 0, 6144, 1'b0, 0, 1'b0);
    drain();

    // 3: word onset, hangover re-entry, then release after four quiet frames
    bus.threshold = 14'd500;
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b0, 0, 1'b0);
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b1, 1, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'd0, 8'd0, 1'b0, 0, 0, 1'b1, 1, 1'b0);
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b1, 1, 1'b0);
    for (int i = 0; i < 3; i++) send_frame(8'd0, 8'd0, 1'b0, 0, 0, 1'b1, 1, 1'b0);
    send_frame(8'd0, 8'd0, 1'b0, 0, 0, 1'b0, 1, 1'b0);
    drain();

    // 4: aborted onset never becomes a word
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b0, 1, 1'b0);
    send_frame(8'd0, 8'd0, 1'b0, 0, 0, 1'b0, 1, 1'b0);
    send_frame(8'd10, 8'd0, 1'b0, 0, 640, 1'b0, 1, 1'b0);
    send_frame(8'd0, 8'd0, 1'b0, 0, 0, 1'b0, 1, 1'b0);
    drain();

    // 6: reset mid-frame discards the partial frame and clears the word count
    for (int i = 0; i < 30; i++) send_sample(8'd10, 8'd0, 1'b0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1;
    send_frame(8'd5, 8'd0, 1'b0, 0, 320, 1'b0, 0, 1'b0);
    drain();

    // 5: ten words wrap the BCD count; odd words use valid every 3rd cycle
    for (int w = 0; w < 10; w++) begin
      int g;
      g = (w % 2 == 1) ? 2 : 0;
      send_frame(8'd10, 8'd0, 1'b0, g, 640, 1'b0, w, 1'b0);
      send_frame(8'd10, 8'd0, 1'b0, g, 640, 1'b1, (w + 1) % 10, 1'b1);
      for (int q = 0; q < 3; q++) send_frame(8'd0, 8'd0, 1'b0, g, 0, 1'b1, (w + 1) % 10, 1'b0);
      send_frame(8'd0, 8'd0, 1'b0, g, 0, 1'b0, (w + 1) % 10, 1'b0);
    end
    drain();

    chk("word_pulse_total", wp_total, 11);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
